cpu_bus_responder: RTL

CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

---
 rtl/cpu_bus_responder_pkg.sv | 20 ++
 rtl/cpu_bus_responder_sync_ram.sv | 22 ++
 rtl/cpu_bus_responder.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_bus_responder_pkg.sv
// Shared widths, memory map and FSM encoding for the CPU bus responder.
package cpu_bus_responder_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int REG_WIDTH  = 8;

  localparam logic [ADDR_WIDTH-1:0] RAM_BASE  = 16'h0000;
  localparam logic [ADDR_WIDTH-1:0] RAM_LIMIT = 16'h1FFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic ram_hit(logic [ADDR_WIDTH-1:0] a);
    return (a - RAM_BASE) <= (RAM_LIMIT - RAM_BASE);
  endfunction

endpackage

// File: rtl/cpu_bus_responder_sync_ram.sv
// Single-port RAM: synchronous write, combinational read of the
// latched access index.
module cpu_bus_responder_sync_ram #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU-side bus responder: RAM below $2000, open-bus elsewhere,
// programmable wait states and a sticky protocol-error flag.
module cpu_bus_responder
  import cpu_bus_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int RAM_AW      = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  r_w_n,
  input  logic                  valid,
  input  logic [REG_WIDTH-1:0]  wdata,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic                  rdata_oe,
  output logic                  rdy,
  output logic                  err
);

  localparam bit HAS_WAIT = WAIT_CYCLES > 0;
  localparam logic [3:0] WAIT_LD =
    4'(HAS_WAIT ? WAIT_CYCLES - 1 : 0);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rw_q;
  logic [REG_WIDTH-1:0]  wd_q;
  logic [REG_WIDTH-1:0]  ob_q;
  logic [REG_WIDTH-1:0]  ram_rd;
  logic                  err_q;
  logic                  accept;
  logic                  in_resp;
  logic                  in_wait;
  logic                  hit;
  logic                  ram_we;

  assign in_resp = state_q == S_RESP;
  assign in_wait = state_q == S_WAIT;
  assign hit     = ram_hit(addr_q);

  // A reset landing on the RESP cycle discards the pending write.
  assign ram_we = in_resp && !rw_q && hit && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (valid) begin
          accept  = 1'b1;
          state_d = HAS_WAIT ? S_WAIT : S_RESP;
          cnt_d   = WAIT_LD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      ob_q    <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_wait && valid) err_q <= 1'b1;
      if (in_resp) ob_q <= rw_q ? rdata : wd_q;
      if (accept) begin
        addr_q <= addr;
        rw_q   <= r_w_n;
        wd_q   <= wdata;
      end
    end
  end

  cpu_bus_responder_sync_ram #(
    .AW (RAM_AW),
    .DW (REG_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_q[RAM_AW-1:0]),
    .wdata (wd_q),
    .rdata (ram_rd)
  );

  assign rdy      = !in_wait;
  assign rdata_oe = in_resp && rw_q && hit;
  assign rdata    = rdata_oe ? ram_rd : ob_q;
  assign err      = err_q;

endmodule
